// File: rtl/fifo_pkg.sv
// Shared helpers for the fifo_level block: level/pointer widths and ring-pointer wrap.
package fifo_pkg;

    // Width able to hold every occupancy value 0..cap.
    function automatic int unsigned lvl_width(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

    // Pointer width; a single-entry ring still gets one (constant-zero) bit.
    function automatic int unsigned ptr_width(input int unsigned cap);
        return (cap > 1) ? $clog2(cap) : 1;
    endfunction

    // Next ring index; wraps explicitly so non-power-of-two capacities stay in range.
    function automatic int unsigned ring_incr(input int unsigned ptr, input int unsigned cap);
        return (ptr >= cap - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ring_ptr.sv
// Ring index register over 0..CAPACITY-1 with synchronous reset, clear and advance.
module fifo_ring_ptr
    import fifo_pkg::*;
#(
    parameter int CAPACITY = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             adv,
    output logic [ptr_width(CAPACITY)-1:0]   ptr
);

    localparam int PW = int'(ptr_width(CAPACITY));

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Clear wins over advance so a flush cycle always lands on index 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (adv) begin
            ptr_d = PW'(ring_incr(32'(ptr_q), CAPACITY));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_level.sv
// Ring-buffer FIFO with registered occupancy, almost-full/almost-empty flags,
// synchronous flush and optional zero-latency pass-through when empty.
module fifo_level
    import fifo_pkg::*;
#(
    parameter type TYPE         = logic,
    parameter int  CAPACITY     = 4,
    parameter bit  PASS_THROUGH = 1'b0,
    parameter int  AF_LEVEL     = CAPACITY - 1,
    parameter int  AE_LEVEL     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  TYPE                              w_data,
    output logic                             r_valid,
    input  logic                             r_ready,
    output TYPE                              r_data,
    output logic [lvl_width(CAPACITY)-1:0]   count,
    output logic                             almost_full,
    output logic                             almost_empty
);

    localparam int CW = int'(lvl_width(CAPACITY));
    localparam int PW = int'(ptr_width(CAPACITY));

    if (CAPACITY < 1) begin : g_bad_capacity
        $fatal(1, "fifo_level: CAPACITY must be >= 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > CAPACITY) begin : g_bad_af_level
        $fatal(1, "fifo_level: AF_LEVEL must be in 1..CAPACITY");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > CAPACITY - 1) begin : g_bad_ae_level
        $fatal(1, "fifo_level: AE_LEVEL must be in 0..CAPACITY-1");
    end

    // Handshake: a transfer happens on a side exactly in a cycle where its
    // valid and ready are both high; flush forces both readies/valids low.
    TYPE           mem_q [CAPACITY];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    logic empty_eff;
    logic full_eff;
    logic wfire;
    logic rfire;
    logic bypass;
    logic push;
    logic pop;

    // While rst is high the FIFO already presents its post-reset face.
    always_comb begin
        empty_eff = rst || (count_q == '0);
        full_eff  = !rst && (count_q == CW'(CAPACITY));
        w_ready   = !flush && (!full_eff || (PASS_THROUGH && r_ready));
        r_valid   = !flush && (!empty_eff || (PASS_THROUGH && w_valid));
        wfire     = w_valid && w_ready;
        rfire     = r_valid && r_ready;
        bypass    = PASS_THROUGH && empty_eff && wfire && rfire;
        push      = wfire && !bypass;
        pop       = rfire && !bypass;
        count_d   = count_q + CW'(push) - CW'(pop);
        if (flush) begin
            count_d = '0;
        end
    end

    always_comb begin
        r_data = mem_q[rptr];
        if (PASS_THROUGH && empty_eff) begin
            r_data = w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr] <= w_data;
        end
    end

    fifo_ring_ptr #(.CAPACITY(CAPACITY)) u_wptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .adv (push),
        .ptr (wptr)
    );

    fifo_ring_ptr #(.CAPACITY(CAPACITY)) u_rptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .adv (pop),
        .ptr (rptr)
    );

    // Flags come from the registered count only, so they trail the handshake by a cycle.
    assign count        = count_q;
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

endmodule
